// File: rtl/mem_io_responder_if.sv
// Purpose : byte-wide RAM port plus UART TX/RX and status lines between the
//           memory controller / board logic (master) and mem_io_responder (slave).
// Ports   : ram_rw/ram_addr/ram_w_data -> slave, ram_r_data <- slave;
//           tx_valid/tx_data <- slave, tx_ready -> slave;
//           rx_valid/rx_data -> slave; io_buffer_full/halt <- slave.
interface mem_io_responder_if;
  logic        ram_rw;
  logic [31:0] ram_addr;
  logic [7:0]  ram_w_data;
  logic [7:0]  ram_r_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        io_buffer_full;
  logic        halt;

  modport master (
    output ram_rw, ram_addr, ram_w_data, tx_ready, rx_valid, rx_data,
    input  ram_r_data, tx_valid, tx_data, io_buffer_full, halt
  );

  modport slave (
    input  ram_rw, ram_addr, ram_w_data, tx_ready, rx_valid, rx_data,
    output ram_r_data, tx_valid, tx_data, io_buffer_full, halt
  );
endinterface

// File: rtl/mem_io_responder.sv
// Purpose : memory-side responder: block RAM below addr[17], MMIO above it
//           (UART TX/RX FIFOs, halt flag, tear-free cycle counter).
// Latency : ram_r_data is registered, valid exactly 1 cycle after the address.
// Backpressure: TX drains on tx_valid&&tx_ready; io_buffer_full warns the
//           controller one slot early; TX overflow and RX-full bytes are dropped.
// Ports   : clock, reset (sync, active-high), bus (mem_io_responder_if.slave).
module mem_io_responder #(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic                clock,
  input  logic                reset,
  mem_io_responder_if.slave   bus
);
  localparam int TPW = $clog2(TX_DEPTH) + 1;
  localparam int RPW = $clog2(RX_DEPTH) + 1;

  logic [7:0]     ram    [2**RAM_AW];
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [7:0]     rx_mem [RX_DEPTH];

  logic [TPW-1:0] tx_wp, tx_rp, tx_count;
  logic [RPW-1:0] rx_wp, rx_rp, rx_count;
  logic           tx_full, tx_empty, rx_full, rx_empty;
  logic           tx_ovf, halt_q;
  logic [31:0]    cyc_cnt;
  logic [31:8]    snap_hi;     // byte 0 is always served live, so it is not held
  logic [7:0]     r_data_q;

  logic           is_io;
  logic [3:0]     io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic           ram_wr, tx_push, tx_pop, tx_push_ok, rx_pop, rx_push_ok;
  logic           snap_load, halt_set;
  logic [7:0]     io_rd_data;
  logic           unused_addr_bits;

  assign is_io   = bus.ram_addr[17];
  assign io_off  = bus.ram_addr[3:0];
  assign ram_idx = bus.ram_addr[RAM_AW-1:0];
  assign unused_addr_bits = ^bus.ram_addr[31:18];

  assign tx_count = tx_wp - tx_rp;
  assign rx_count = rx_wp - rx_rp;
  assign tx_full  = (tx_count == TPW'(TX_DEPTH));
  assign rx_full  = (rx_count == RPW'(RX_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_empty = (rx_count == '0);

  // Reset gates every write side effect, so a write in the reset cycle is lost.
  assign ram_wr     = !reset && !is_io && bus.ram_rw;
  assign tx_push    = !reset && is_io && bus.ram_rw && (io_off == 4'h0);
  assign tx_pop     = !tx_empty && bus.tx_ready;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign tx_push_ok = tx_push && (!tx_full || tx_pop);
  assign rx_pop     = is_io && !bus.ram_rw && (io_off == 4'h0) && !rx_empty;
  assign rx_push_ok = !reset && bus.rx_valid && (!rx_full || rx_pop);
  assign snap_load  = is_io && !bus.ram_rw && (io_off == 4'h8);
  assign halt_set   = is_io && bus.ram_rw && (io_off == 4'h4);

  always_comb begin
    io_rd_data = 8'h00;
    case (io_off)
      4'h0: io_rd_data = rx_empty ? 8'h00 : rx_mem[rx_rp[RPW-2:0]];
      4'h4: io_rd_data = {6'b0, tx_ovf, !rx_empty};
      4'h8: io_rd_data = cyc_cnt[7:0];
      4'h9: io_rd_data = snap_hi[15:8];
      4'hA: io_rd_data = snap_hi[23:16];
      4'hB: io_rd_data = snap_hi[31:24];
      default: io_rd_data = 8'h00;
    endcase
  end

  // Storage arrays carry no reset; their contents are qualified by the pointers.
  always_ff @(posedge clock) begin
    if (ram_wr)     ram[ram_idx] <= bus.ram_w_data;
    if (tx_push_ok) tx_mem[tx_wp[TPW-2:0]] <= bus.ram_w_data;
    if (rx_push_ok) rx_mem[rx_wp[RPW-2:0]] <= bus.rx_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data_q <= 8'h00;
      tx_wp    <= '0;
      tx_rp    <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      tx_ovf   <= 1'b0;
      halt_q   <= 1'b0;
      cyc_cnt  <= 32'd0;
      snap_hi  <= '0;
    end else begin
      // The RAM read sees the pre-write contents: read-first on a same-address write.
      r_data_q <= is_io ? io_rd_data : ram[ram_idx];
      if (tx_push_ok)            tx_wp  <= tx_wp + TPW'(1);
      if (tx_pop)                tx_rp  <= tx_rp + TPW'(1);
      if (tx_push && !tx_push_ok) tx_ovf <= 1'b1;
      if (rx_push_ok)            rx_wp  <= rx_wp + RPW'(1);
      if (rx_pop)                rx_rp  <= rx_rp + RPW'(1);
      if (halt_set)              halt_q <= 1'b1;
      if (!halt_q)               cyc_cnt <= cyc_cnt + 32'd1;
      if (snap_load)             snap_hi <= cyc_cnt[31:8];
    end
  end

  assign bus.ram_r_data     = r_data_q;
  assign bus.tx_valid       = !tx_empty;
  assign bus.tx_data        = tx_mem[tx_rp[TPW-2:0]];
  assign bus.io_buffer_full = (tx_count >= TPW'(TX_DEPTH - 1));
  assign bus.halt           = halt_q;
endmodule
